// File: rtl/if_fetch_unit_pkg.sv
// +----------------------------------------------------------------------+
// | if_pkg : shared types and constants for the IF stage.    Rev 1.0     |
// +----------------------------------------------------------------------+
`default_nettype none

package if_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] BUBBLE_INSTR = 32'h0000_0000;
  localparam logic [31:0] INSTR_BYTES  = 32'd4;

endpackage

`default_nettype wire

// File: rtl/if_fetch_unit_if.sv
// +----------------------------------------------------------------------+
// | if_fetch_unit_if : req/ack instruction-memory bus.       Rev 1.0     |
// +----------------------------------------------------------------------+
`default_nettype none

interface if_fetch_unit_if;

  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_data_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_ack_i,
    input  imem_data_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_ack_i,
    output imem_data_i
  );

endinterface

`default_nettype wire

// File: rtl/if_fetch_unit.sv
// +----------------------------------------------------------------------+
// | if_fetch_unit : PC owner, imem handshake, one-word skid. Rev 1.0     |
// +----------------------------------------------------------------------+
`default_nettype none

module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  wire logic               clk_i,
  input  wire logic               start_i,
  input  wire logic               Stall_i,
  input  wire logic               Branch_i,
  input  wire logic [31:0]        BranchTarget_i,
  if_fetch_unit_if.master         imem,
  output logic [31:0]             PC_o,
  output logic [31:0]             instr_o,
  output logic                    valid_o
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  addr_q;
  logic [31:0]  skid_q;
  logic [31:0]  out_pc_q;
  logic [31:0]  out_instr_q;
  logic         out_valid_q;

  logic         req;
  logic         ack;
  logic         consume;
  logic         slot_free;
  logic [31:0]  target;
  logic [31:0]  pc_inc;

  // No request is issued while the skid holds a word.
  assign req       = start_i & (state_q != HOLD);
  assign ack       = req & imem.imem_ack_i;
  assign consume   = out_valid_q & ~Stall_i;
  assign slot_free = ~out_valid_q | ~Stall_i;
  assign target    = BranchTarget_i & ~32'h0000_0003;
  assign pc_inc    = pc_q + INSTR_BYTES;

  assign imem.imem_req_o  = req;
  assign imem.imem_addr_o = addr_q;

  assign PC_o    = out_pc_q;
  assign instr_o = out_instr_q;
  assign valid_o = out_valid_q;

  always_ff @(posedge clk_i) begin
    if (!start_i) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      addr_q      <= RESET_PC;
      skid_q      <= BUBBLE_INSTR;
      out_pc_q    <= '0;
      out_instr_q <= BUBBLE_INSTR;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          if (Branch_i) begin
            pc_q        <= target;
            out_pc_q    <= '0;
            out_instr_q <= BUBBLE_INSTR;
            out_valid_q <= 1'b0;
            if (ack) begin
              addr_q <= target;
            end else begin
              state_q <= DROP;
            end
          end else if (ack) begin
            pc_q <= pc_inc;
            if (slot_free) begin
              out_pc_q    <= addr_q;
              out_instr_q <= imem.imem_data_i;
              out_valid_q <= 1'b1;
              addr_q      <= pc_inc;
            end else begin
              // addr_q keeps the PC of the word parked in the skid.
              skid_q  <= imem.imem_data_i;
              state_q <= HOLD;
            end
          end else if (consume) begin
            out_pc_q    <= '0;
            out_instr_q <= BUBBLE_INSTR;
            out_valid_q <= 1'b0;
          end
        end

        HOLD: begin
          if (Branch_i) begin
            pc_q        <= target;
            addr_q      <= target;
            skid_q      <= BUBBLE_INSTR;
            out_pc_q    <= '0;
            out_instr_q <= BUBBLE_INSTR;
            out_valid_q <= 1'b0;
            state_q     <= FETCH;
          end else if (consume) begin
            out_pc_q    <= addr_q;
            out_instr_q <= skid_q;
            out_valid_q <= 1'b1;
            addr_q      <= pc_q;
            state_q     <= FETCH;
          end
        end

        DROP: begin
          // Waiting out the stale request; the newest redirect wins.
          out_pc_q    <= '0;
          out_instr_q <= BUBBLE_INSTR;
          out_valid_q <= 1'b0;
          if (Branch_i) begin
            pc_q <= target;
          end
          if (ack) begin
            addr_q  <= Branch_i ? target : pc_q;
            state_q <= FETCH;
          end
        end

        default: begin
          state_q <= FETCH;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
// +----------------------------------------------------------------------+
// | tb_if_fetch_unit : random stimulus vs. stream-level reference model. |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        start_i;
  logic        Stall_i;
  logic        Branch_i;
  logic [31:0] BranchTarget_i;
  logic [31:0] PC_o;
  logic [31:0] instr_o;
  logic        valid_o;

  always #5 clk = ~clk;

  if_fetch_unit_if imem_bus ();

  if_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk_i          (clk),
    .start_i        (start_i),
    .Stall_i        (Stall_i),
    .Branch_i       (Branch_i),
    .BranchTarget_i (BranchTarget_i),
    .imem           (imem_bus),
    .PC_o           (PC_o),
    .instr_o        (instr_o),
    .valid_o        (valid_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Memory contents: a fixed function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h0001_0193) ^ 32'h0050_0093 ^ {a[15:0], a[31:16]};
  endfunction

  // Memory model state
  bit          mem_busy = 1'b0;
  int          mem_wait = 0;
  logic [31:0] mem_addr = '0;

  // Reference model: next PC expected on the output stream, next address
  // expected to be fetched, and whether the outstanding request is stale.
  logic [31:0] exp_pc   = RESET_PC;
  logic [31:0] fetch_pc = RESET_PC;
  bit          stale    = 1'b0;

  // Previous-cycle record
  bit          p_start  = 1'b0;
  bit          p_stall  = 1'b0;
  bit          p_branch = 1'b0;
  logic [31:0] p_tgt    = '0;
  bit          p_req    = 1'b0;
  bit          p_ack    = 1'b0;
  logic [31:0] p_addr   = '0;
  bit          p_valid  = 1'b0;
  logic [31:0] p_pc     = '0;
  logic [31:0] p_instr  = '0;

  task automatic check_outputs();
    bit held;
    if (!valid_o) begin
      check_eq("bubble_pc", PC_o, 32'h0);
      check_eq("bubble_instr", instr_o, 32'h0);
    end else begin
      check_eq("instr_data", instr_o, mem_word(PC_o));
    end

    if (!p_start) begin
      check_eq("reset_valid", {31'b0, valid_o}, 32'd0);
      exp_pc   = RESET_PC;
      fetch_pc = RESET_PC;
      stale    = 1'b0;
      return;
    end

    if (p_branch) begin
      check_eq("branch_flush", {31'b0, valid_o}, 32'd0);
      exp_pc   = p_tgt & ~32'h3;
      fetch_pc = p_tgt & ~32'h3;
      stale    = p_req & ~p_ack;
      return;
    end

    held = p_valid & p_stall;
    if (held) begin
      check_eq("stall_valid", {31'b0, valid_o}, 32'd1);
      check_eq("stall_pc", PC_o, p_pc);
      check_eq("stall_instr", instr_o, p_instr);
    end

    if (p_ack) begin
      if (stale) begin
        stale = 1'b0;
        if (!held) check_eq("stale_discard", {31'b0, valid_o}, 32'd0);
      end else begin
        check_eq("fetch_addr", p_addr, fetch_pc);
        fetch_pc = fetch_pc + 32'd4;
        if (!held) begin
          check_eq("ack_latency_valid", {31'b0, valid_o}, 32'd1);
          check_eq("ack_latency_pc", PC_o, p_addr);
        end else begin
          check_eq("hold_req_low", {31'b0, imem_bus.imem_req_o}, 32'd0);
        end
      end
    end else if (p_req && !held) begin
      check_eq("wait_bubble", {31'b0, valid_o}, 32'd0);
    end

    if (valid_o && !held) begin
      check_eq("stream_order", PC_o, exp_pc);
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic do_cycle(input bit st, input bit stall, input bit br, input logic [31:0] tgt);
    @(negedge clk);
    check_outputs();
    start_i        = st;
    Stall_i        = stall;
    Branch_i       = br;
    BranchTarget_i = tgt;
    #1;
    if (!st) check_eq("req_in_reset", {31'b0, imem_bus.imem_req_o}, 32'd0);

    if (imem_bus.imem_req_o) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_wait = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
        mem_addr = imem_bus.imem_addr_o;
      end else begin
        check_eq("addr_stable", imem_bus.imem_addr_o, mem_addr);
      end
      if (mem_wait == 0) begin
        imem_bus.imem_ack_i  = 1'b1;
        imem_bus.imem_data_i = mem_word(imem_bus.imem_addr_o);
        mem_busy = 1'b0;
      end else begin
        imem_bus.imem_ack_i  = 1'b0;
        imem_bus.imem_data_i = $urandom;
        mem_wait--;
      end
    end else begin
      // Request dropped (reset) or absent: ack line carries noise.
      mem_busy = 1'b0;
      imem_bus.imem_ack_i  = 1'($urandom_range(0, 1));
      imem_bus.imem_data_i = $urandom;
    end

    p_start  = st;
    p_stall  = stall;
    p_branch = br;
    p_tgt    = tgt;
    p_req    = imem_bus.imem_req_o;
    p_ack    = imem_bus.imem_req_o & imem_bus.imem_ack_i;
    p_addr   = imem_bus.imem_addr_o;
    p_valid  = valid_o;
    p_pc     = PC_o;
    p_instr  = instr_o;
  endtask

  initial begin
    bit          st;
    bit          stall;
    bit          br;
    logic [31:0] tgt;

    start_i              = 1'b0;
    Stall_i              = 1'b0;
    Branch_i             = 1'b0;
    BranchTarget_i       = '0;
    imem_bus.imem_ack_i  = 1'b0;
    imem_bus.imem_data_i = '0;

    repeat (3) do_cycle(1'b0, 1'b0, 1'b0, 32'h0);

    // Clean zero-stall stream first, then a wrap-around redirect.
    repeat (12) do_cycle(1'b1, 1'b0, 1'b0, 32'h0);
    do_cycle(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE);
    repeat (10) do_cycle(1'b1, 1'b0, 1'b0, 32'h0);

    for (int i = 0; i < 4000; i++) begin
      st    = ($urandom_range(0, 199) != 0);
      stall = ($urandom_range(0, 3) == 0);
      br    = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 3))
        0:       tgt = 32'hFFFF_FFFC;
        1:       tgt = $urandom;
        default: tgt = 32'($urandom_range(0, 255)) * 32'd4 + 32'h100;
      endcase
      do_cycle(st, stall, br, tgt);
    end

    do_cycle(1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check_outputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
